// File: rtl/uart_tx_scheduler.sv
// Round-robin arbiter that feeds four byte requesters into a single UART transmitter.
// It issues one frame at a time and holds off the next grant until the frame and its guard time have elapsed.
module uart_tx_scheduler #(
  parameter int ClockFrequency = 50_000_000,
  parameter int BaudRate       = 115200,
  parameter int GuardCycles    = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [3:0]  i_req_valid,
  input  logic [31:0] i_req_data,
  output logic [3:0]  o_req_ready,
  output logic        o_send,
  output logic [7:0]  o_frame,
  output logic        o_busy,
  output logic [1:0]  o_grant_id
);

  localparam int TicksPerBit = ClockFrequency / BaudRate;
  localparam int FrameCycles = 10 * TicksPerBit + GuardCycles;
  localparam int CntW        = $clog2(FrameCycles + 1);
  localparam logic [CntW-1:0] CntLoad = CntW'(FrameCycles - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t          state_reg;
  logic [CntW-1:0] cnt_reg;
  logic [1:0]      ptr_reg;
  logic            send_reg;
  logic [7:0]      frame_reg;
  logic [1:0]      grant_reg;

  logic [1:0] cand [4];
  logic [7:0] req_byte [4];
  logic [3:0] hit;
  logic       win_valid;
  logic [1:0] win_id;

  // Candidate gi is the requester visited at step gi of the search starting after ptr.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_cand
      assign cand[gi]     = ptr_reg + 2'(gi + 1);
      assign hit[gi]      = i_req_valid[cand[gi]];
      assign req_byte[gi] = i_req_data[8*gi +: 8];
    end
  endgenerate

  always_comb begin
    win_valid = |hit;
    win_id    = ptr_reg;
    for (int k = 3; k >= 0; k--) begin
      if (hit[k]) win_id = cand[k];
    end
  end

  always_comb begin
    o_req_ready = '0;
    if (state_reg == IDLE && RST && win_valid) o_req_ready[win_id] = 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      ptr_reg   <= 2'd3;
      send_reg  <= 1'b0;
      frame_reg <= 8'h00;
      grant_reg <= 2'd3;
    end else begin
      send_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (win_valid) begin
            frame_reg <= req_byte[win_id];
            grant_reg <= win_id;
            ptr_reg   <= win_id;
            send_reg  <= 1'b1;
            state_reg <= ISSUE;
          end
        end
        ISSUE: begin
          cnt_reg   <= CntLoad;
          state_reg <= WAIT;
        end
        WAIT: begin
          if (cnt_reg == '0) state_reg <= IDLE;
          else               cnt_reg   <= cnt_reg - CntW'(1);
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // A reset arriving during ISSUE suppresses the pulse in that same cycle.
  assign o_send     = send_reg & RST;
  assign o_frame    = frame_reg;
  assign o_grant_id = grant_reg;
  assign o_busy     = (state_reg != IDLE);

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Self-checking bench for uart_tx_scheduler: directed scenarios plus random traffic,
// compared cycle by cycle against a timestamp-based reference model.
module tb_uart_tx_scheduler;

  localparam int ClockFrequency = 400;
  localparam int BaudRate       = 100;
  localparam int GuardCycles    = 2;
  localparam int FrameCycles    = 10 * (ClockFrequency / BaudRate) + GuardCycles;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic [3:0]  i_req_valid = '0;
  logic [31:0] i_req_data = '0;
  logic [3:0]  o_req_ready;
  logic        o_send;
  logic [7:0]  o_frame;
  logic        o_busy;
  logic [1:0]  o_grant_id;

  uart_tx_scheduler #(
    .ClockFrequency(ClockFrequency),
    .BaudRate(BaudRate),
    .GuardCycles(GuardCycles)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .i_req_valid(i_req_valid),
    .i_req_data(i_req_data),
    .o_req_ready(o_req_ready),
    .o_send(o_send),
    .o_frame(o_frame),
    .o_busy(o_busy),
    .o_grant_id(o_grant_id)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: the block is free from cycle idle_at onward; the start pulse is due at cycle issue_at.
  int         cyc = 0;
  int         idle_at = 0;
  int         issue_at = -10;
  logic [1:0] m_ptr = 2'd3;
  logic [1:0] m_grant = 2'd3;
  logic [7:0] m_frame = 8'h00;
  logic [3:0] last_grant_mask = '0;
  logic       prev_send = 1'b0;
  int         busy_cnt = 0;
  int         grant_log[$];
  int         grant_cyc_log[$];
  int         send_log[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic int rr_pick(input logic [1:0] ptr, input logic [3:0] v);
    for (int off = 1; off <= 4; off++) begin
      int idx;
      idx = (int'(ptr) + off) % 4;
      if (v[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic tick();
    bit         idle;
    int         w;
    logic [3:0] exp_ready;
    logic       exp_send;
    @(negedge CLK);
    idle      = (cyc >= idle_at);
    w         = rr_pick(m_ptr, i_req_valid);
    exp_ready = (RST && idle && w >= 0) ? 4'(1 << w) : 4'b0000;
    exp_send  = RST && (cyc == issue_at);
    check("ready", 32'(o_req_ready), 32'(exp_ready));
    check("send", 32'(o_send), 32'(exp_send));
    check("busy", 32'(o_busy), 32'(!idle));
    check("frame", 32'(o_frame), 32'(m_frame));
    check("grant_id", 32'(o_grant_id), 32'(m_grant));
    check("ready_onehot0", 32'($onehot0(o_req_ready)), 32'd1);
    check("send_consecutive", 32'(o_send && prev_send), 32'd0);
    prev_send = o_send;
    if (o_busy) busy_cnt++;
    if (o_send) send_log.push_back(cyc);
    for (int k = 0; k < 4; k++) begin
      if (o_req_ready[k]) begin
        grant_log.push_back(k);
        grant_cyc_log.push_back(cyc);
      end
    end
    if (!RST) begin
      idle_at  = cyc + 1;
      issue_at = -10;
      m_ptr    = 2'd3;
      m_grant  = 2'd3;
      m_frame  = 8'h00;
    end else if (exp_ready != 4'b0000) begin
      m_frame  = i_req_data[8*w +: 8];
      m_grant  = 2'(w);
      m_ptr    = 2'(w);
      issue_at = cyc + 1;
      idle_at  = cyc + 2 + FrameCycles;
    end
    last_grant_mask = exp_ready;
    cyc++;
    @(posedge CLK);
    #1;
  endtask

  task automatic reset_pulse();
    RST = 1'b0;
    tick();
    RST = 1'b1;
  endtask

  task automatic clear_logs();
    grant_log.delete();
    grant_cyc_log.delete();
    send_log.delete();
    busy_cnt = 0;
  endtask

  initial begin
    int g;
    i_req_data = $urandom;
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b1;
    check("reset_busy", 32'(o_busy), 32'd0);
    check("reset_send", 32'(o_send), 32'd0);
    check("reset_frame", 32'(o_frame), 32'h00);
    check("reset_grant", 32'(o_grant_id), 32'd3);

    // Single request from requester 2
    clear_logs();
    i_req_data[23:16] = 8'hA5;
    i_req_valid = 4'b0100;
    tick();
    i_req_valid = 4'b0000;
    check("s1_send", 32'(o_send), 32'd1);
    check("s1_frame", 32'(o_frame), 32'hA5);
    check("s1_grant", 32'(o_grant_id), 32'd2);
    repeat (50) tick();
    check("s1_busy_len", 32'(busy_cnt), 32'(FrameCycles + 1));
    check("s1_grant_count", 32'(grant_log.size()), 32'd1);
    if (grant_log.size() >= 1) check("s1_grant_idx", 32'(grant_log[0]), 32'd2);

    // All four requesters pending continuously after reset
    reset_pulse();
    clear_logs();
    i_req_data = $urandom;
    i_req_valid = 4'b1111;
    repeat (4 * (FrameCycles + 2) + 5) tick();
    i_req_valid = 4'b0000;
    check("s2_grant_count", 32'(grant_log.size()), 32'd5);
    for (int i = 0; i < 5 && i < grant_log.size(); i++)
      check($sformatf("s2_order%0d", i), 32'(grant_log[i]), 32'(i % 4));
    for (int i = 1; i < send_log.size(); i++)
      check($sformatf("s2_spacing%0d", i), 32'(send_log[i] - send_log[i-1]), 32'(FrameCycles + 2));
    repeat (FrameCycles + 2) tick();

    // Requester 1 holds valid, requester 3 raises valid once per frame
    reset_pulse();
    clear_logs();
    i_req_valid = 4'b0010;
    for (int i = 0; i < 4 * (FrameCycles + 2) + 5; i++) begin
      tick();
      if (last_grant_mask[3]) i_req_valid[3] = 1'b0;
      if (last_grant_mask[1]) i_req_valid[3] = 1'b1;
    end
    i_req_valid = 4'b0000;
    check("s3_grant_count", 32'(grant_log.size()), 32'd5);
    for (int i = 0; i < 4 && i < grant_log.size(); i++)
      check($sformatf("s3_alt%0d", i), 32'(grant_log[i]), (i % 2 == 0) ? 32'd1 : 32'd3);
    repeat (FrameCycles + 2) tick();

    // Request rising mid-WAIT waits for the first IDLE cycle
    clear_logs();
    i_req_valid = 4'b0100;
    g = cyc;
    tick();
    i_req_valid = 4'b0000;
    repeat (20) tick();
    i_req_valid = 4'b0001;
    repeat (30) tick();
    i_req_valid = 4'b0000;
    check("s4_grant_count", 32'(grant_log.size()), 32'd2);
    if (grant_log.size() == 2) begin
      check("s4_late_idx", 32'(grant_log[1]), 32'd0);
      check("s4_late_cycle", 32'(grant_cyc_log[1]), 32'(g + FrameCycles + 2));
    end
    repeat (FrameCycles + 2) tick();

    // Reset in WAIT with the counter at 20
    clear_logs();
    i_req_valid = 4'b0010;
    g = cyc;
    tick();
    i_req_valid = 4'b0000;
    while (cyc < g + 2 + (FrameCycles - 1 - 20)) tick();
    RST = 1'b0;
    i_req_valid = 4'b1111;
    tick();
    RST = 1'b1;
    check("s5_busy", 32'(o_busy), 32'd0);
    check("s5_send", 32'(o_send), 32'd0);
    check("s5_grant", 32'(o_grant_id), 32'd3);
    tick();
    check("s5_regrant", 32'(last_grant_mask), 32'b0001);
    i_req_valid = 4'b0000;
    repeat (FrameCycles + 2) tick();

    // Random traffic with occasional reset pulses and withdrawn requests
    for (int i = 0; i < 1500; i++) begin
      RST = ($urandom_range(0, 199) != 0);
      for (int k = 0; k < 4; k++) begin
        if (last_grant_mask[k]) begin
          i_req_valid[k] = 1'b0;
        end else if (!i_req_valid[k]) begin
          if ($urandom_range(0, 9) == 0) begin
            i_req_data[8*k +: 8] = 8'($urandom);
            i_req_valid[k] = 1'b1;
          end
        end else if ($urandom_range(0, 49) == 0) begin
          i_req_valid[k] = 1'b0;
        end
      end
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
